if_fetch_buffer: RTL and testbench

Instruction-fetch front end that sits directly upstream of the decode-stage controller. It issues sequential requests to a synchronous instruction memory, buffers returned words with their PCs in a small FIFO, and presents one instruction per cycle to decode under a valid/ready handshake. Control-flow redirects from execute flush the buffer and restart fetch.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/if_fetch_buffer.sv | 107 ++++++++++
 tb/tb_if_fetch_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // Sequential PC step; 32'hFFFF_FFFC wraps to 0 naturally.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two FIFO of {pc, instr} entries with synchronous clear.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  fetch_entry_t             i_wdata,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output fetch_entry_t             o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;

  assign w_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_clear) begin
      assert (!(i_push && w_full && !i_pop)) else $error("fetch_fifo: push into full FIFO");
      assert (!(i_pop && o_empty)) else $error("fetch_fifo: pop from empty FIFO");
    end
  end

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch front end: sequential imem requests, {pc,instr} buffer, valid/ready to decode.
// Optional FETCH_BYPASS_EN lets a response reach decode in its arrival cycle when empty.
//
// Handshake: an instruction transfers to decode in a cycle where dec_valid and
// dec_ready are both high and no redirect is present; dec_valid never depends on
// dec_ready, and the head outputs stay stable while dec_valid is held without ready.
module if_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     dec_ready,
  output logic                     dec_valid,
  output logic [31:0]              InstrD,
  output logic [31:0]              PCD,
  output logic [31:0]              PCPlus4D,
  output logic [$clog2(DEPTH):0]   dbg_count,
  output logic                     dbg_inflight
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] OCC_LIMIT = (CW+1)'(DEPTH);

  logic [31:0]  r_fetch_pc;
  logic         r_inflight;
  logic [31:0]  r_inflight_pc;
  fetch_entry_t r_last;

  logic [CW-1:0] w_count;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_resp;
  fetch_entry_t  w_out;
  logic          w_out_valid;
  logic          w_resp_valid;
  logic          w_fifo_push;
  logic          w_fifo_pop;
  logic          w_pop;
  logic [CW:0]   w_occ;

  // A response is dropped when a redirect flushes or reset clears this cycle.
  assign w_resp_valid = r_inflight & ~redirect_valid & ~reset;
  assign w_resp       = {r_inflight_pc, imem_rdata};

`ifdef FETCH_BYPASS_EN
  assign w_out_valid = ~w_empty | w_resp_valid;
  assign w_out       = !w_empty ? w_head : (w_resp_valid ? w_resp : r_last);
  assign w_fifo_push = w_resp_valid & ~(w_empty & w_pop);
`else
  assign w_out_valid = ~w_empty;
  assign w_out       = w_empty ? r_last : w_head;
  assign w_fifo_push = w_resp_valid;
`endif

  assign dec_valid  = w_out_valid & ~redirect_valid & ~reset;
  assign w_pop      = dec_valid & dec_ready;
  assign w_fifo_pop = w_pop & ~w_empty;

  // The in-flight slot is counted so a returning word always has room.
  assign w_occ     = (CW+1)'(w_count) + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign imem_req  = ~reset & (redirect_valid | (w_occ < OCC_LIMIT));
  assign imem_addr = redirect_valid ? redirect_pc : r_fetch_pc;

  assign InstrD       = w_out.instr;
  assign PCD          = w_out.pc;
  assign PCPlus4D     = pc_plus4(w_out.pc);
  assign dbg_count    = w_count;
  assign dbg_inflight = r_inflight;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (redirect_valid),
    .i_push  (w_fifo_push),
    .i_wdata (w_resp),
    .i_pop   (w_fifo_pop),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_last        <= '0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_fetch_pc    <= pc_plus4(imem_addr);
        r_inflight_pc <= imem_addr;
      end
      // Remembered so decode outputs hold their last value while empty.
      if (dec_valid) r_last <= w_out;
    end
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: per-cycle vector table, corner sequences, PC scoreboard.
module tb_if_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [$clog2(DEPTH):0] dbg_count;
  logic        dbg_inflight;

  if_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .dbg_count      (dbg_count),
    .dbg_inflight   (dbg_inflight)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data one cycle after the request
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ XOR_PAT;
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected PC stream, popped on each decode transfer
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;
  bit          sb_en = 1'b0;

  always @(negedge clk) begin
    if (sb_en && dec_valid && dec_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got PCD %h expected nothing", PCD);
      end else begin
        sb_e = exp_q.pop_front();
        check32("sb_pcd", PCD, sb_e);
        check32("sb_instr", InstrD, sb_e ^ XOR_PAT);
        check32("sb_pcplus4", PCPlus4D, sb_e + 32'd4);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_q(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic do_reset(input int n);
    sb_en          = 1'b0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic start_run(input logic ready);
    reset     = 1'b0;
    dec_ready = ready;
    fill_q(32'h0, 64);
    sb_en     = 1'b1;
  endtask

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pcd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].ready     = 1'b1;
      vecs[i].exp_req   = 1'b1;
      vecs[i].exp_addr  = 32'(4 * i);
      vecs[i].exp_valid = (i >= LAT);
      vecs[i].exp_pcd   = (i >= LAT) ? 32'(4 * (i - LAT)) : 32'h0;
    end

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b1;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check32("rst_imem_req", 32'(imem_req), 32'd0);
    check32("rst_dec_valid", 32'(dec_valid), 32'd0);
    check32("rst_pcd", PCD, 32'h0);
    check32("rst_instr", InstrD, 32'h0);
    check32("rst_pcplus4", PCPlus4D, 32'h4);
    check32("rst_count", 32'(dbg_count), 32'd0);
    check32("rst_inflight", 32'(dbg_inflight), 32'd0);

    // Reset release, streaming, table-driven per-cycle checks
    tick();
    start_run(1'b1);
    for (int i = 0; i < 8; i++) begin
      dec_ready = vecs[i].ready;
      @(negedge clk);
      check32($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      check32($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check32($sformatf("vec%0d_valid", i), 32'(dec_valid), 32'(vecs[i].exp_valid));
      check32($sformatf("vec%0d_pcd", i), PCD, vecs[i].exp_pcd);
      tick();
    end

    // Stall for 10 cycles, then release
    do_reset(2);
    start_run(1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= LAT) begin
        check32($sformatf("stall%0d_valid", c), 32'(dec_valid), 32'd1);
        check32($sformatf("stall%0d_pcd", c), PCD, 32'h0);
      end
      if (c == 3) check32("stall_req_open", 32'(imem_req), 32'd1);
      if (c == 9) begin
        check32("stall_req_closed", 32'(imem_req), 32'd0);
        check32("stall_count_full", 32'(dbg_count), 32'(DEPTH));
      end
      tick();
    end
    dec_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check32($sformatf("release%0d_valid", c), 32'(dec_valid), 32'd1);
      tick();
    end

    // Redirect to 0x100 with 3 buffered entries, decode ready in the same cycle
    do_reset(2);
    start_run(1'b0);
    repeat (4) tick();
    check32("redir_pre_count", 32'(dbg_count), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    dec_ready      = 1'b1;
    fill_q(32'h0000_0100, 64);
    @(negedge clk);
    check32("redir_r_valid", 32'(dec_valid), 32'd0);
    check32("redir_r_req", 32'(imem_req), 32'd1);
    check32("redir_r_addr", imem_addr, 32'h0000_0100);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check32("redir_r1_valid", 32'(dec_valid), 32'(LAT == 1));
    repeat (LAT - 1) tick();
    @(negedge clk);
    check32("redir_target_pcd", PCD, 32'h0000_0100);
    repeat (6) tick();

    // Redirect while head is 0x20 and ready; target wraps through zero
    do_reset(2);
    start_run(1'b1);
    repeat (8 + LAT) tick();
    check32("wrap_pre_head", PCD, 32'h0000_0020);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    fill_q(32'hFFFF_FFFC, 64);
    @(negedge clk);
    check32("wrap_r_valid", 32'(dec_valid), 32'd0);
    check32("wrap_r_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    repeat (LAT - 1) tick();
    @(negedge clk);
    check32("wrap_pcd0", PCD, 32'hFFFF_FFFC);
    check32("wrap_pc4_0", PCPlus4D, 32'h0);
    tick();
    @(negedge clk);
    check32("wrap_pcd1", PCD, 32'h0);
    check32("wrap_pc4_1", PCPlus4D, 32'h4);
    repeat (4) tick();

    // Reset with a request in flight and the buffer at capacity
    do_reset(2);
    start_run(1'b0);
    repeat (4) tick();
    check32("mrst_pre_count", 32'(dbg_count), 32'd3);
    check32("mrst_pre_inflight", 32'(dbg_inflight), 32'd1);
    reset = 1'b1;
    sb_en = 1'b0;
    tick();
    start_run(1'b1);
    @(negedge clk);
    check32("mrst_count", 32'(dbg_count), 32'd0);
    check32("mrst_valid", 32'(dec_valid), 32'd0);
    check32("mrst_inflight", 32'(dbg_inflight), 32'd0);
    check32("mrst_addr", imem_addr, 32'h0);
    repeat (8) tick();

    do_reset(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
